// File: rtl/cvp14_pkg.sv
// Shared definitions for the cvp14 vector datapath: functype codes, operand entry layout
// and small width-extension helpers used when forming scalar/offset operands.
package cvp14_pkg;

    localparam int LANES_DEF  = 16;
    localparam int LANE_W_DEF = 16;
    localparam int VW_DEF     = LANES_DEF * LANE_W_DEF;

    localparam logic [3:0] FT_VADD = 4'h0;
    localparam logic [3:0] FT_VDOT = 4'h1;
    localparam logic [3:0] FT_SMUL = 4'h2;
    localparam logic [3:0] FT_SST  = 4'h3;
    localparam logic [3:0] FT_VLD  = 4'h4;
    localparam logic [3:0] FT_VST  = 4'h5;
    localparam logic [3:0] FT_SLL  = 4'h6;
    localparam logic [3:0] FT_SLH  = 4'h7;
    localparam logic [3:0] FT_NOP  = 4'hF;

    // Buffered entry at the default geometry; parametrised instances use the same
    // {functype, op1, op2} ordering in a flat vector.
    typedef struct packed {
        logic [3:0]        functype;
        logic [VW_DEF-1:0] op1;
        logic [VW_DEF-1:0] op2;
    } entry_t;

    // Helpers work in a 32-bit container; callers truncate to the lane width.
    function automatic logic [31:0] low_mask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] zext(input logic [31:0] v, input int w);
        return v & low_mask(w);
    endfunction

    function automatic logic [31:0] sext(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = v & low_mask(w);
        if (|(v & (32'd1 << (w - 1))))
            r = r | ~low_mask(w);
        return r;
    endfunction

    // Codes 8..E are undefined; F is NOP and is legal.
    function automatic logic is_illegal(input logic [3:0] ft);
        return ft[3] && (ft != FT_NOP);
    endfunction

endpackage

// File: rtl/operand_fifo2.sv
// Two-entry FIFO holding formed operand entries. Entry 0 is always the head;
// a pop shifts entry 1 down so the head never needs a read pointer.
module operand_fifo2 #(
    parameter int WIDTH = 516
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem0;
    logic [WIDTH-1:0] mem1;
    logic [1:0]       wr_idx;

    assign wr_idx = pop ? (count - 2'd1) : count;
    assign dout   = mem0;

    always_ff @(posedge clk) begin
        if (rst || flush)
            count <= 2'd0;
        else
            count <= count + {1'b0, push} - {1'b0, pop};
    end

    // Data needs no reset: the top masks the head whenever count is zero.
    // When push and pop coincide at count 1, the push into slot 0 overrides the shift.
    always_ff @(posedge clk) begin
        if (pop)
            mem0 <= mem1;
        if (push) begin
            if (wr_idx == 2'd0)
                mem0 <= din;
            else
                mem1 <= din;
        end
    end

endmodule

// File: rtl/operand_issue_stage.sv
// Registered operand picker with a 2-entry valid/ready buffer.
// Optional downstream stall counter enabled by defining OPERAND_STALL_PERF_EN.
module operand_issue_stage
    import cvp14_pkg::*;
#(
    parameter int LANES  = 16,
    parameter int LANE_W = 16,
    parameter int OFF_W  = 6,
    parameter int IMM_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              functype,
    input  logic [LANES*LANE_W-1:0] vectorData1,
    input  logic [LANES*LANE_W-1:0] vectorData2,
    input  logic [LANE_W-1:0]       scalarData1,
    input  logic [LANE_W-1:0]       scalarData2,
    input  logic [IMM_W-1:0]        immediate,
    input  logic [OFF_W-1:0]        offset,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              out_functype,
    output logic [LANES*LANE_W-1:0] op1,
    output logic [LANES*LANE_W-1:0] op2,
    output logic                    illegal_op,
    output logic [31:0]             stall_cnt
);

    localparam int VW = LANES * LANE_W;
    localparam int EW = 4 + 2 * VW;

    logic [VW-1:0] op1_n;
    logic [VW-1:0] op2_n;
    logic          accept;
    logic          push;
    logic          pop;
    logic [1:0]    count;
    logic [EW-1:0] head;

    assign in_ready  = (count != 2'd2);
    assign accept    = in_valid && in_ready;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    // NOP and undefined codes complete the handshake but never occupy a slot.
    assign push      = accept && !functype[3] && !flush;

    always_comb begin
        op1_n = '0;
        op2_n = '0;
        case (functype)
            FT_VADD, FT_VDOT: begin
                op1_n = vectorData1;
                op2_n = vectorData2;
            end
            FT_SMUL: begin
                op1_n = vectorData1;
                op2_n = {LANES{scalarData1}};
            end
            FT_SST: begin
                op1_n[LANE_W-1:0]        = scalarData1;
                op1_n[2*LANE_W-1:LANE_W] = scalarData2;
                op2_n[LANE_W-1:0]        = LANE_W'(sext(32'(offset), OFF_W));
            end
            FT_VLD, FT_VST: begin
                op1_n[LANE_W-1:0] = scalarData1;
                op2_n[LANE_W-1:0] = LANE_W'(sext(32'(offset), OFF_W));
            end
            FT_SLL, FT_SLH: begin
                op1_n[LANE_W-1:0] = scalarData1;
                op2_n[LANE_W-1:0] = LANE_W'(zext(32'(immediate), IMM_W));
            end
            default: ;
        endcase
    end

    operand_fifo2 #(
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   ({functype, op1_n, op2_n}),
        .dout  (head),
        .count (count)
    );

    assign out_functype = out_valid ? head[EW-1 -: 4]     : FT_NOP;
    assign op1          = out_valid ? head[2*VW-1:VW]     : '0;
    assign op2          = out_valid ? head[VW-1:0]        : '0;

    // Reported even when a flush discards the same-cycle accept.
    always_ff @(posedge clk) begin
        if (rst)
            illegal_op <= 1'b0;
        else
            illegal_op <= accept && is_illegal(functype);
    end

`ifdef OPERAND_STALL_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= 32'd0;
        else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF))
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed bench for operand_issue_stage: queue-based reference model checked every
// cycle, plus literal expectations for the headline scenarios.
module tb_operand_issue_stage;

    localparam int LANES = 16;
    localparam int LW    = 16;
    localparam int VW    = LANES * LW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    functype = 4'hF;
    logic [VW-1:0] vectorData1 = '0;
    logic [VW-1:0] vectorData2 = '0;
    logic [LW-1:0] scalarData1 = '0;
    logic [LW-1:0] scalarData2 = '0;
    logic [7:0]    immediate = '0;
    logic [5:0]    offset = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [3:0]    out_functype;
    logic [VW-1:0] op1;
    logic [VW-1:0] op2;
    logic          illegal_op;
    logic [31:0]   stall_cnt;

    always #5 clk = ~clk;

    operand_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .functype(functype), .vectorData1(vectorData1), .vectorData2(vectorData2),
        .scalarData1(scalarData1), .scalarData2(scalarData2), .immediate(immediate),
        .offset(offset), .out_valid(out_valid), .out_ready(out_ready),
        .out_functype(out_functype), .op1(op1), .op2(op2), .illegal_op(illegal_op),
        .stall_cnt(stall_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: a queue of formed entries plus expected pulse/counter state.
    typedef struct {
        logic [3:0]    ft;
        logic [VW-1:0] o1;
        logic [VW-1:0] o2;
    } ment_t;

    ment_t       mq[$];
    logic        exp_ill = 1'b0;
    logic [31:0] exp_stall = 32'd0;
    int          n_now;
    bit          acc_now;
    int          ill_pulses = 0;

    function automatic ment_t form(input logic [3:0] ft);
        ment_t e;
        e.ft = ft;
        e.o1 = '0;
        e.o2 = '0;
        if (ft == 4'h0 || ft == 4'h1) begin
            e.o1 = vectorData1;
            e.o2 = vectorData2;
        end else if (ft == 4'h2) begin
            e.o1 = vectorData1;
            for (int i = 0; i < LANES; i++) e.o2[i*LW +: LW] = scalarData1;
        end else begin
            e.o1[LW-1:0] = scalarData1;
            if (ft == 4'h3) e.o1[2*LW-1:LW] = scalarData2;
            if (ft <= 4'h5) e.o2[LW-1:0] = 16'($signed(offset));
            else            e.o2[LW-1:0] = 16'(immediate);
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            exp_ill   = 1'b0;
            exp_stall = 32'd0;
        end else begin
            n_now   = mq.size();
            acc_now = in_valid && (n_now != 2);
`ifdef OPERAND_STALL_PERF_EN
            if (n_now != 0 && !out_ready && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
`endif
            exp_ill = acc_now && functype >= 4'h8 && functype <= 4'hE;
            if (flush) mq.delete();
            else begin
                if (n_now != 0 && out_ready) void'(mq.pop_front());
                if (acc_now && functype < 4'h8) mq.push_back(form(functype));
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", VW'(out_valid), VW'(mq.size() != 0));
        chk("in_ready", VW'(in_ready), VW'(mq.size() != 2));
        chk("out_functype", VW'(out_functype), VW'(mq.size() != 0 ? mq[0].ft : 4'hF));
        chk("op1", op1, mq.size() != 0 ? mq[0].o1 : '0);
        chk("op2", op2, mq.size() != 0 ? mq[0].o2 : '0);
        chk("illegal_op", VW'(illegal_op), VW'(exp_ill));
        chk("stall_cnt", VW'(stall_cnt), VW'(exp_stall));
        if (illegal_op) ill_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, VW'(out_valid), VW'(0));
        chk({tag, "_in_ready"}, VW'(in_ready), VW'(1));
        chk({tag, "_out_functype"}, VW'(out_functype), VW'(4'hF));
        chk({tag, "_op1"}, op1, '0);
        chk({tag, "_op2"}, op2, '0);
        chk({tag, "_illegal"}, VW'(illegal_op), VW'(0));
        chk({tag, "_stall"}, VW'(stall_cnt), VW'(0));
    endtask

    task automatic push_tag(input logic [15:0] tag);
        functype    = 4'h0;
        vectorData1 = '0;
        vectorData1[15:0] = tag;
        vectorData2 = '0;
        in_valid    = 1'b1;
    endtask

    logic [15:0] got[$];
    int          ill_before;
    bit          acc;

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // 1: VADD, lane i = i and 2i
        out_ready = 1'b1;
        functype  = 4'h0;
        for (int i = 0; i < LANES; i++) begin
            vectorData1[i*LW +: LW] = 16'(i);
            vectorData2[i*LW +: LW] = 16'(2 * i);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", VW'(out_valid), VW'(1));
        chk("t1_op1_lane3", VW'(op1[3*LW +: LW]), VW'(16'd3));
        chk("t1_op2_lane15", VW'(op2[15*LW +: LW]), VW'(16'd30));
        chk("t1_in_ready", VW'(in_ready), VW'(1));
        tick();

        // 2: SMUL broadcast then VLD negative offset
        functype    = 4'h2;
        scalarData1 = 16'hBEEF;
        in_valid    = 1'b1;
        tick();
        chk("t2_smul_lane5", VW'(op2[5*LW +: LW]), VW'(16'hBEEF));
        chk("t2_smul_lane0", VW'(op2[LW-1:0]), VW'(16'hBEEF));
        functype    = 4'h4;
        scalarData1 = 16'h1234;
        offset      = 6'b111110;
        tick();
        in_valid = 1'b0;
        chk("t2_vld_op2", op2, VW'(16'hFFFE));
        chk("t2_vld_op1", op1, VW'(16'h1234));
        // SST and SLL through the model as well
        functype = 4'h3; scalarData2 = 16'h5A5A; offset = 6'b000101; in_valid = 1'b1;
        tick();
        chk("t2_sst_op1", op1, VW'(32'h5A5A_1234));
        functype = 4'h6; immediate = 8'hF0;
        tick();
        in_valid = 1'b0;
        chk("t2_sll_op2", op2, VW'(16'h00F0));
        tick();

        // 3: backpressure, three back-to-back pushes
        out_ready = 1'b0;
        push_tag(16'd1);
        tick();
        push_tag(16'd2);
        tick();
        chk("t3_in_ready_full", VW'(in_ready), VW'(0));
        push_tag(16'd3);
        tick();
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            acc = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(op1[15:0]);
            tick();
            if (acc) in_valid = 1'b0;
        end
        chk("t3_pop_count", VW'(got.size()), VW'(3));
        for (int k = 0; k < 3; k++)
            chk("t3_order", VW'(k < got.size() ? got[k] : 16'hDEAD), VW'(k + 1));

        // 4: NOP then undefined code
        ill_before = ill_pulses;
        functype = 4'hF; in_valid = 1'b1;
        tick();
        chk("t4_nop_valid", VW'(out_valid), VW'(0));
        chk("t4_nop_ill", VW'(illegal_op), VW'(0));
        functype = 4'h9;
        tick();
        in_valid = 1'b0;
        chk("t4_ill_pulse", VW'(illegal_op), VW'(1));
        chk("t4_ill_valid", VW'(out_valid), VW'(0));
        tick();
        tick();
        chk("t4_pulse_count", VW'(ill_pulses - ill_before), VW'(1));

        // 5: flush at count 2 with in_valid, then flush at count 1 with an accept
        out_ready = 1'b0;
        push_tag(16'd7);
        tick();
        push_tag(16'd8);
        tick();
        push_tag(16'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_valid", VW'(out_valid), VW'(0));
        chk("t5_in_ready", VW'(in_ready), VW'(1));
        push_tag(16'd10);
        tick();
        push_tag(16'd11);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("t5_flush_accept", VW'(out_valid), VW'(0));
        for (int k = 0; k < 3; k++) tick();

        // 6: stall counter, then reset mid-stall
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        push_tag(16'd12);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
`ifdef OPERAND_STALL_PERF_EN
        chk("t6_stall10", VW'(stall_cnt), VW'(10));
`else
        chk("t6_stall_tied", VW'(stall_cnt), VW'(0));
`endif
        chk("t6_still_valid", VW'(out_valid), VW'(1));
        rst = 1'b1;
        tick();
        check_reset_outputs("t6_midreset");
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
